// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared AXI4-Lite definitions for the host register block:
//               response codes and the byte-to-word address offset.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

  typedef logic [1:0] resp_t;

  // AXI response codes used by this slave
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Registers are 32-bit words, so the word index starts at byte-address bit 2
  localparam int ADDR_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/axil_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : axil_reg_bank
// Description : Register storage for the AXI-Lite register block. One write
//               port (full-word, range checked) and one combinational read
//               port that returns zero for out-of-range addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int C_DATA_W   = 32,
  parameter int C_ADDR_W   = 32,
  parameter int C_NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [C_ADDR_W-1:0] i_wr_addr,
  input  logic [C_DATA_W-1:0] i_wr_data,
  output logic                o_wr_err,
  input  logic [C_ADDR_W-1:0] i_rd_addr,
  output logic [C_DATA_W-1:0] o_rd_data,
  output logic                o_rd_err
);

  localparam int IDX_W   = $clog2(C_NUM_REGS);
  localparam int IDX_MSB = IDX_W + ADDR_LSB - 1;

  logic [C_DATA_W-1:0] r_regs [C_NUM_REGS];

  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_unused;

  // Any set bit above the index field means the access is past the last register
  assign w_wr_idx      = i_wr_addr[IDX_MSB:ADDR_LSB];
  assign w_rd_idx      = i_rd_addr[IDX_MSB:ADDR_LSB];
  assign w_wr_in_range = (i_wr_addr[C_ADDR_W-1:IDX_MSB+1] == '0);
  assign w_rd_in_range = (i_rd_addr[C_ADDR_W-1:IDX_MSB+1] == '0);

  assign o_wr_err = ~w_wr_in_range;
  assign o_rd_err = ~w_rd_in_range;

  // Byte-offset bits inside a word carry no meaning for full-word registers
  assign w_unused = &{1'b0, i_wr_addr[ADDR_LSB-1:0], i_rd_addr[ADDR_LSB-1:0]};

  // Storage: cleared on reset, full-word replace on an in-range write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en && w_wr_in_range) begin
      r_regs[w_wr_idx] <= i_wr_data;
    end
  end

  // Read mux: out-of-range reads return zero
  always_comb begin
    o_rd_data = '0;
    if (w_rd_in_range) begin
      o_rd_data = r_regs[w_rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_reg_block.sv
`default_nettype none
// ============================================================================
// Module      : axil_reg_block
// Description : AXI4-Lite slave exposing C_NUM_REGS read/write registers.
//               Independent single-beat write and read channels, each a
//               small handshake FSM (ready pulse, then response valid).
// Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_block
  import axil_pkg::*;
#(
  parameter int C_DATA_W   = 32,
  parameter int C_ADDR_W   = 32,
  parameter int C_NUM_REGS = 16
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic [C_ADDR_W-1:0] s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [C_DATA_W-1:0] s_axi_wdata,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [C_ADDR_W-1:0] s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [C_DATA_W-1:0] s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam logic [1:0] WR_IDLE   = 2'd0;
  localparam logic [1:0] WR_ACCEPT = 2'd1;
  localparam logic [1:0] WR_RESP   = 2'd2;

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_ACCEPT = 2'd1;
  localparam logic [1:0] RD_VALID  = 2'd2;

  logic [1:0]          r_wr_state;
  logic [1:0]          w_wr_state_next;
  logic [1:0]          r_rd_state;
  logic [1:0]          w_rd_state_next;
  logic                w_wr_hs;
  logic                w_rd_hs;
  logic                w_wr_err;
  logic                w_rd_err;
  logic [C_DATA_W-1:0] w_rd_data;
  resp_t               r_bresp;
  resp_t               r_rresp;
  logic [C_DATA_W-1:0] r_rdata;

  // A write lands on the edge where both ready pulses meet both valids
  assign w_wr_hs = (r_wr_state == WR_ACCEPT) && s_axi_awvalid && s_axi_wvalid;
  assign w_rd_hs = (r_rd_state == RD_ACCEPT) && s_axi_arvalid;

  axil_reg_bank #(
    .C_DATA_W   (C_DATA_W),
    .C_ADDR_W   (C_ADDR_W),
    .C_NUM_REGS (C_NUM_REGS)
  ) u_bank (
    .clk       (s_axi_aclk),
    .rst       (s_axi_areset),
    .i_wr_en   (w_wr_hs),
    .i_wr_addr (s_axi_awaddr),
    .i_wr_data (s_axi_wdata),
    .o_wr_err  (w_wr_err),
    .i_rd_addr (s_axi_araddr),
    .o_rd_data (w_rd_data),
    .o_rd_err  (w_rd_err)
  );

  // Write channel state register
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_wr_state <= WR_IDLE;
    else              r_wr_state <= w_wr_state_next;
  end

  // Write channel next state: only a full AW+W pair is accepted, one at a time
  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE:   if (s_axi_awvalid && s_axi_wvalid) w_wr_state_next = WR_ACCEPT;
      WR_ACCEPT: w_wr_state_next = w_wr_hs ? WR_RESP : WR_IDLE;
      WR_RESP:   if (s_axi_bready) w_wr_state_next = WR_IDLE;
      default:   w_wr_state_next = WR_IDLE;
    endcase
  end

  // Write channel outputs decoded from state
  always_comb begin
    s_axi_awready = (r_wr_state == WR_ACCEPT);
    s_axi_wready  = (r_wr_state == WR_ACCEPT);
    s_axi_bvalid  = (r_wr_state == WR_RESP);
  end

  // Write response code captured at the handshake, held until the next write
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset)  r_bresp <= RESP_OKAY;
    else if (w_wr_hs)  r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
  end

  // Read channel state register
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_rd_state <= RD_IDLE;
    else              r_rd_state <= w_rd_state_next;
  end

  // Read channel next state: one outstanding read, released by rready
  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE:   if (s_axi_arvalid) w_rd_state_next = RD_ACCEPT;
      RD_ACCEPT: w_rd_state_next = w_rd_hs ? RD_VALID : RD_IDLE;
      RD_VALID:  if (s_axi_rready) w_rd_state_next = RD_IDLE;
      default:   w_rd_state_next = RD_IDLE;
    endcase
  end

  // Read channel outputs decoded from state
  always_comb begin
    s_axi_arready = (r_rd_state == RD_ACCEPT);
    s_axi_rvalid  = (r_rd_state == RD_VALID);
  end

  // Read data sampled at the handshake edge, so a same-edge write is not seen
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_hs) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_axi_bresp = r_bresp;
  assign s_axi_rdata = r_rdata;
  assign s_axi_rresp = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_reg_block
// Description : Self-checking bench for axil_reg_block: directed scenarios
//               plus randomized traffic against an array-based register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_reg_block;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_areset;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int total = 0;
  int bad   = 0;

  // Expected register contents, indexed by word
  logic [31:0] model [16];

  always #5 s_axi_aclk = ~s_axi_aclk;

  axil_reg_block #(
    .C_DATA_W   (32),
    .C_ADDR_W   (32),
    .C_NUM_REGS (16)
  ) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_areset  (s_axi_areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (a < 32'd64) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return (a < 32'd64) ? model[a / 4] : 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'd64) model[a / 4] = d;
  endtask

  // Finish a write whose awvalid/wvalid are already being driven
  task automatic wr_complete(input string tag, output logic [1:0] resp);
    int n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin tick(); n++; end
    check({tag, "_accept"}, {31'd0, s_axi_awready && s_axi_wready}, 32'd1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    check({tag, "_blat"}, n, 32'd0);
    check({tag, "_bvalid"}, {31'd0, s_axi_bvalid}, 32'd1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick();
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    wr_complete("wr", resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    check("rd_accept", {31'd0, s_axi_arready}, 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    check("rd_latency", n, 32'd0);
    check("rd_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
    d    = s_axi_rdata;
    resp = s_axi_rresp;
    tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, r);
    check($sformatf("bresp@%0h", a), {30'd0, r}, {30'd0, exp_resp(a)});
    model_write(a, d);
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check($sformatf("rdata@%0h", a), d, exp_rdata(a));
    check($sformatf("rresp@%0h", a), {30'd0, r}, {30'd0, exp_resp(a)});
  endtask

  // Write and read launched together; the read must see the pre-write value
  task automatic do_both(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  wr;
    exp_d = exp_rdata(ra);
    exp_r = exp_resp(ra);
    fork
      axi_write(wa, wd, wr);
      axi_read(ra, rd, rr);
    join
    check($sformatf("both_bresp@%0h", wa), {30'd0, wr}, {30'd0, exp_resp(wa)});
    check($sformatf("both_rdata@%0h", ra), rd, exp_d);
    check($sformatf("both_rresp@%0h", ra), {30'd0, rr}, {30'd0, exp_r});
    model_write(wa, wd);
  endtask

  initial begin
    int          n;
    logic [1:0]  r;
    logic [31:0] a;
    logic [31:0] d;

    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    s_axi_areset  = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    repeat (3) tick();
    s_axi_areset = 1'b0;
    tick();

    // Reset state
    check("rst_awready", {31'd0, s_axi_awready}, 32'd0);
    check("rst_wready",  {31'd0, s_axi_wready},  32'd0);
    check("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
    check("rst_arready", {31'd0, s_axi_arready}, 32'd0);
    check("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
    check("rst_rdata",   s_axi_rdata,            32'd0);
    check("rst_bresp",   {30'd0, s_axi_bresp},   32'd0);
    check("rst_rresp",   {30'd0, s_axi_rresp},   32'd0);

    // Basic write then read
    do_write(32'h0C, 32'hDEADBEEF);
    do_read(32'h0C);

    // Fill all registers, read back, check sub-word alias
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 16; i++) do_read(32'(i * 4));
    do_read(32'h0D);

    // Backpressure on B blocks a second write
    s_axi_awaddr  = 32'h14;
    s_axi_wdata   = 32'h1111_2222;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b0;
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(); n++; end
    check("bp_first_accept", {31'd0, s_axi_awready}, 32'd1);
    tick();
    model_write(32'h14, 32'h1111_2222);
    s_axi_awaddr = 32'h18;
    s_axi_wdata  = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_held", {31'd0, s_axi_bvalid},  32'd1);
      check("bp_no_awready",  {31'd0, s_axi_awready}, 32'd0);
      check("bp_bresp",       {30'd0, s_axi_bresp},   32'd0);
      tick();
    end
    s_axi_bready = 1'b1;
    tick();
    check("bp_bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
    wr_complete("bp_second", r);
    check("bp_second_bresp", {30'd0, r}, 32'd0);
    model_write(32'h18, 32'h3333_4444);
    do_read(32'h14);
    do_read(32'h18);

    // Address without data is held off until data arrives
    s_axi_awaddr  = 32'h20;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("aw_only_awready", {31'd0, s_axi_awready}, 32'd0);
      check("aw_only_wready",  {31'd0, s_axi_wready},  32'd0);
    end
    do_read(32'h20);
    s_axi_wdata  = 32'hA5A5_5A5A;
    s_axi_wvalid = 1'b1;
    wr_complete("aw_then_w", r);
    check("aw_then_w_bresp", {30'd0, r}, 32'd0);
    model_write(32'h20, 32'hA5A5_5A5A);
    do_read(32'h20);

    // Out-of-range write and read
    do_write(32'h40, 32'hFFFF_FFFF);
    for (int i = 0; i < 16; i++) do_read(32'(i * 4));
    do_read(32'h40);

    // Randomized traffic, including out-of-range and same-edge accesses
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 79));
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       do_write(a, d);
        1:       do_read(a);
        default: do_both(a, d, ((i % 3) == 0) ? a : 32'($urandom_range(0, 79)));
      endcase
    end

    // Reset while a read response is waiting
    do_write(32'h0C, 32'hCAFE_F00D);
    s_axi_araddr  = 32'h0C;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    check("mid_rst_accept", {31'd0, s_axi_arready}, 32'd1);
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    tick();
    check("mid_rst_rvalid_held", {31'd0, s_axi_rvalid}, 32'd1);
    check("mid_rst_rdata_held",  s_axi_rdata,            32'hCAFE_F00D);
    #2;
    s_axi_areset = 1'b1;
    #1;
    check("mid_rst_rvalid_clear", {31'd0, s_axi_rvalid}, 32'd0);
    check("mid_rst_rdata_clear",  s_axi_rdata,            32'd0);
    tick();
    s_axi_areset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    tick();
    do_read(32'h0C);
    do_read(32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
